// File: rtl/spdif_stream_scheduler.sv
// spdif_stream_scheduler: alternating L/R feed to the S/PDIF sub-frame encoder with underrun fill and channel status
module spdif_stream_scheduler #(
    parameter logic [3:0] FS_CODE     = 4'b0010,
    parameter logic [7:0] CATEGORY    = 8'h00,
    parameter logic       COPY_PERMIT = 1'b1,
    parameter logic [2:0] WLEN_CODE   = 3'b101,
    parameter logic       FILL_ZERO   = 1'b1
) (
    input  logic        clk128,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_left,
    input  logic [23:0] s_right,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        o_is_left,
    output logic [23:0] o_audio,
    output logic        o_user,
    output logic        o_control,
    input  logic [8:0]  sub_frame_number,
    output logic        underrun_pulse,
    output logic [15:0] underrun_count
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] SEND_L = 2'd2;
    localparam logic [1:0] SEND_R = 2'd3;
    logic [1:0]  state;
    logic [23:0] right;
    logic [7:0]  f;
    logic [1:0]  wi;
    logic [3:0]  wl;
    logic        xfer;
    logic        fill;
    // handshake, transfer qualifiers and channel-status bit for the current frame
    always_comb begin
        s_ready   = state == LOAD;
        o_valid   = state[1];
        o_user    = 1'b0;
        xfer      = o_valid && o_ready;
        fill      = FILL_ZERO && !s_valid && o_ready;
        f         = sub_frame_number[8:1];
        wi        = f[1:0] - 2'd1;
        wl        = {1'b0, WLEN_CODE};
        o_control = f == 8'd2 ? COPY_PERMIT :
                    (f >= 8'd8  && f <= 8'd15) ? CATEGORY[f[2:0]] :
                    (f >= 8'd24 && f <= 8'd27) ? FS_CODE[f[1:0]] :
                    f == 8'd32 ? 1'b1 :
                    (f >= 8'd33 && f <= 8'd35) ? wl[wi] : 1'b0;
    end
    // pair sequencer: latch a pair (or silence), then present left and right in order
    always_ff @(posedge clk128) begin
        if (!reset_n) begin
            state          <= IDLE;
            right          <= '0;
            o_is_left      <= 1'b1;
            o_audio        <= '0;
            underrun_pulse <= 1'b0;
            underrun_count <= '0;
        end else begin
            underrun_pulse <= 1'b0;
            case (state)
                IDLE: if (enable) state <= LOAD;
                LOAD: if (s_valid || fill) begin
                    state     <= SEND_L;
                    o_is_left <= 1'b1;
                    o_audio   <= s_valid ? s_left : '0;
                    right     <= s_valid ? s_right : '0;
                    if (!s_valid) begin
                        underrun_pulse <= 1'b1;
                        if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
                    end
                end
                SEND_L: if (xfer) begin
                    state     <= SEND_R;
                    o_is_left <= 1'b0;
                    o_audio   <= right;
                end
                SEND_R: if (xfer) state <= enable ? LOAD : IDLE;
            endcase
        end
    end
endmodule
